pc_gen_unit: RTL and testbench

//  Stage-1 program-counter generator: registered successor of the combinational PC mux.

---
 rtl/pc_gen_unit.sv | 123 ++++++++++++
 tb/tb_pc_gen_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - stage-1 program-counter generator driving the AHB fetch address
// Tracks AHB address/data phases and buffers one redirect arriving while the bus stalls.
module pc_gen_unit #(
  parameter int             XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter bit             C_EXT     = 1'b0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [1:0]      pc_src_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-2:0] iaddr_in,
  input  logic            instr_16b_in,
  input  logic            ahb_ready_in,
  output logic [XLEN-1:0] iaddr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic            misaligned_instr_logic_out,
  output logic            redirect_pending_out
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PEND} state_t;

  localparam logic [XLEN-1:0] BIT0_CLR = {{(XLEN-1){1'b1}}, 1'b0};

  state_t          state_q, state_d;
  logic [XLEN-1:0] iaddr_q, iaddr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic [1:0]      pend_prio_q, pend_prio_d;

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] seq;
  logic [1:0]      prio;
  logic            redir, illegal, legal, wins;

  // Priority encoding: boot > trap > epc > branch.
  always_comb begin
    tgt  = {iaddr_in, 1'b0};
    prio = 2'd0;
    case (pc_src_in)
      2'b00:   begin tgt = BOOT_ADDR;                  prio = 2'd3; end
      2'b01:   begin tgt = epc_in & BIT0_CLR;          prio = 2'd1; end
      2'b10:   begin tgt = trap_address_in & BIT0_CLR; prio = 2'd2; end
      default: begin tgt = {iaddr_in, 1'b0};           prio = 2'd0; end
    endcase
  end

  assign redir   = (pc_src_in != 2'b11) || branch_taken_in;
  assign illegal = redir && !C_EXT && tgt[1];
  assign legal   = redir && !illegal;
  assign wins    = legal && (prio >= pend_prio_q);
  assign seq     = {iaddr_q[XLEN-1:2], 2'b00} + XLEN'(4);

  always_comb begin
    state_d     = state_q;
    iaddr_d     = iaddr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    mis_d       = illegal;
    pend_addr_d = pend_addr_q;
    pend_prio_d = pend_prio_q;
    case (state_q)
      ST_BOOT, ST_RUN: begin
        if (ahb_ready_in) begin
          pc_d    = iaddr_q;
          valid_d = 1'b1;
          iaddr_d = legal ? tgt : seq;
          state_d = ST_RUN;
        end else if (legal) begin
          pend_addr_d = tgt;
          pend_prio_d = prio;
          state_d     = ST_PEND;
        end
      end
      ST_PEND: begin
        if (ahb_ready_in) begin
          pc_d    = iaddr_q;
          valid_d = 1'b1;
          iaddr_d = wins ? tgt : pend_addr_q;
          state_d = ST_RUN;
        end else if (wins) begin
          pend_addr_d = tgt;
          pend_prio_d = prio;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_BOOT;
      iaddr_q     <= BOOT_ADDR;
      pc_q        <= BOOT_ADDR;
      valid_q     <= 1'b0;
      mis_q       <= 1'b0;
      pend_addr_q <= '0;
      pend_prio_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      iaddr_q     <= iaddr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
      pend_addr_q <= pend_addr_d;
      pend_prio_q <= pend_prio_d;
    end
  end

  assign iaddr_out                  = iaddr_q;
  assign pc_out                     = pc_q;
  assign pc_valid_out               = valid_q;
  assign misaligned_instr_logic_out = mis_q;
  assign redirect_pending_out       = (state_q == ST_PEND);
  assign pc_plus_4_out              = pc_q + ((C_EXT && instr_16b_in) ? XLEN'(2) : XLEN'(4));

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - directed vector bench for pc_gen_unit
// Two instances share stimulus: u_dut (C_EXT=0, boot 0) and u_dut_c (C_EXT=1, boot 0x1000).
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_src = 2'b11;
  logic [31:0] epc = '0, trap = '0;
  logic        br = 1'b0;
  logic [30:0] iaddr_in = '0;
  logic        i16 = 1'b0;
  logic        ready = 1'b0;

  logic [31:0] iaddr0, pc0, pc40;
  logic        valid0, mis0, pend0;
  logic [31:0] iaddr1, pc1, pc41;
  logic        valid1, mis1, pend1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(.XLEN(32), .BOOT_ADDR(32'h0), .C_EXT(1'b0)) u_dut (
    .clk_in(clk), .rst_in(rst), .pc_src_in(pc_src), .epc_in(epc),
    .trap_address_in(trap), .branch_taken_in(br), .iaddr_in(iaddr_in),
    .instr_16b_in(i16), .ahb_ready_in(ready), .iaddr_out(iaddr0), .pc_out(pc0),
    .pc_valid_out(valid0), .pc_plus_4_out(pc40),
    .misaligned_instr_logic_out(mis0), .redirect_pending_out(pend0));

  pc_gen_unit #(.XLEN(32), .BOOT_ADDR(32'h1000), .C_EXT(1'b1)) u_dut_c (
    .clk_in(clk), .rst_in(rst), .pc_src_in(pc_src), .epc_in(epc),
    .trap_address_in(trap), .branch_taken_in(br), .iaddr_in(iaddr_in),
    .instr_16b_in(i16), .ahb_ready_in(ready), .iaddr_out(iaddr1), .pc_out(pc1),
    .pc_valid_out(valid1), .pc_plus_4_out(pc41),
    .misaligned_instr_logic_out(mis1), .redirect_pending_out(pend1));

  typedef struct {
    logic [1:0]  src;
    logic        br;
    logic [31:0] epc;
    logic [31:0] trap;
    logic [31:0] tgt;
    logic        ready;
    logic        i16;
    logic [31:0] e_iaddr;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_pend;
    logic        e_mis;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] s, input logic b, input logic [31:0] e,
                              input logic [31:0] t, input logic [31:0] g, input logic r,
                              input logic h, input logic [31:0] ei, input logic [31:0] ep,
                              input logic ev, input logic epd, input logic em);
    vec_t v;
    v.src = s; v.br = b; v.epc = e; v.trap = t; v.tgt = g; v.ready = r; v.i16 = h;
    v.e_iaddr = ei; v.e_pc = ep; v.e_valid = ev; v.e_pend = epd; v.e_mis = em;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sequential fetch from boot
    vecs[0]  = mk(2'b11,0,0,0,0,1,0, 32'h4,   32'h0,   1,0,0);
    vecs[1]  = mk(2'b11,0,0,0,0,1,0, 32'h8,   32'h4,   1,0,0);
    vecs[2]  = mk(2'b11,0,0,0,0,1,0, 32'hC,   32'h8,   1,0,0);
    vecs[3]  = mk(2'b11,0,0,0,0,1,0, 32'h10,  32'hC,   1,0,0);
    vecs[4]  = mk(2'b11,1,0,0,32'h40,1,0, 32'h40, 32'h10, 1,0,0);
    // branch during stall, 3 pending cycles
    vecs[5]  = mk(2'b11,1,0,0,32'h100,0,0, 32'h40, 32'h10, 1,1,0);
    vecs[6]  = mk(2'b11,0,0,0,0,0,0, 32'h40,  32'h10,  1,1,0);
    vecs[7]  = mk(2'b11,0,0,0,0,0,0, 32'h40,  32'h10,  1,1,0);
    vecs[8]  = mk(2'b11,0,0,0,0,1,0, 32'h100, 32'h40,  1,0,0);
    // branch then trap while stalled
    vecs[9]  = mk(2'b11,1,0,0,32'h100,0,0, 32'h100, 32'h40, 1,1,0);
    vecs[10] = mk(2'b10,0,0,32'h200,0,0,0, 32'h100, 32'h40, 1,1,0);
    vecs[11] = mk(2'b11,0,0,0,0,1,0, 32'h200, 32'h100, 1,0,0);
    // trap then branch while stalled
    vecs[12] = mk(2'b10,0,0,32'h200,0,0,0, 32'h200, 32'h100, 1,1,0);
    vecs[13] = mk(2'b11,1,0,0,32'h100,0,0, 32'h200, 32'h100, 1,1,0);
    vecs[14] = mk(2'b11,0,0,0,0,1,0, 32'h200, 32'h200, 1,0,0);
    // buffered epc beats a same-cycle branch on release
    vecs[15] = mk(2'b01,0,32'h300,0,0,0,0, 32'h200, 32'h200, 1,1,0);
    vecs[16] = mk(2'b11,1,0,0,32'h400,1,0, 32'h300, 32'h200, 1,0,0);
    // misaligned branch and epc dropped
    vecs[17] = mk(2'b11,1,0,0,32'h102,1,0, 32'h304, 32'h300, 1,0,1);
    vecs[18] = mk(2'b11,0,0,0,0,1,0, 32'h308, 32'h304, 1,0,0);
    vecs[19] = mk(2'b01,0,32'h402,0,0,1,0, 32'h30C, 32'h308, 1,0,1);
    vecs[20] = mk(2'b01,0,32'h401,0,0,1,0, 32'h400, 32'h30C, 1,0,0);
    // wraparound
    vecs[21] = mk(2'b10,0,0,32'hFFFF_FFFC,0,1,0, 32'hFFFF_FFFC, 32'h400, 1,0,0);
    vecs[22] = mk(2'b11,0,0,0,0,1,1, 32'h0, 32'hFFFF_FFFC, 1,0,0);
    // boot redirect
    vecs[23] = mk(2'b00,0,0,0,0,1,0, 32'h0, 32'h0, 1,0,0);
    vecs[24] = mk(2'b11,0,0,0,0,1,0, 32'h4, 32'h0, 1,0,0);

    tick();
    tick();
    check("rst_iaddr0", iaddr0, 32'h0);
    check("rst_pc0", pc0, 32'h0);
    check("rst_valid0", {31'b0, valid0}, 32'h0);
    check("rst_mis0", {31'b0, mis0}, 32'h0);
    check("rst_pend0", {31'b0, pend0}, 32'h0);
    check("rst_iaddr1", iaddr1, 32'h1000);
    check("rst_pc1", pc1, 32'h1000);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      pc_src   = vecs[i].src;
      br       = vecs[i].br;
      epc      = vecs[i].epc;
      trap     = vecs[i].trap;
      iaddr_in = vecs[i].tgt[31:1];
      ready    = vecs[i].ready;
      i16      = vecs[i].i16;
      tick();
      check($sformatf("v%0d_iaddr", i), iaddr0, vecs[i].e_iaddr);
      check($sformatf("v%0d_pc", i), pc0, vecs[i].e_pc);
      check($sformatf("v%0d_valid", i), {31'b0, valid0}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d_pend", i), {31'b0, pend0}, {31'b0, vecs[i].e_pend});
      check($sformatf("v%0d_mis", i), {31'b0, mis0}, {31'b0, vecs[i].e_mis});
      check($sformatf("v%0d_pc4", i), pc40, vecs[i].e_pc + 32'd4);
    end

    // compressed-ISA instance from a fresh reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    pc_src = 2'b11; br = 1'b0; ready = 1'b1; i16 = 1'b0;
    tick();
    check("c_boot_iaddr", iaddr1, 32'h1004);
    check("c_boot_pc", pc1, 32'h1000);
    check("c_boot_valid", {31'b0, valid1}, 32'h1);
    br = 1'b1; iaddr_in = 31'h81;
    tick();
    check("c_half_iaddr", iaddr1, 32'h102);
    check("c_half_mis", {31'b0, mis1}, 32'h0);
    br = 1'b0;
    tick();
    check("c_half_seq", iaddr1, 32'h104);
    check("c_half_pc", pc1, 32'h102);
    pc_src = 2'b10; trap = 32'hFFFF_FFFC;
    tick();
    pc_src = 2'b11;
    tick();
    check("c_wrap_iaddr", iaddr1, 32'h0);
    check("c_wrap_pc", pc1, 32'hFFFF_FFFC);
    check("c_wrap_pc4", pc41, 32'h0);
    i16 = 1'b1;
    #1;
    check("c_wrap_pc2", pc41, 32'hFFFF_FFFE);
    check("c0_wrap_pc4_16b", pc40, pc0 + 32'd4);
    i16 = 1'b0;

    // async reset in the middle of a pending redirect
    ready = 1'b0; br = 1'b1; iaddr_in = 31'h80;
    tick();
    br = 1'b0;
    check("pend_before_rst0", {31'b0, pend0}, 32'h1);
    check("pend_before_rst1", {31'b0, pend1}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_iaddr0", iaddr0, 32'h0);
    check("arst_iaddr1", iaddr1, 32'h1000);
    check("arst_pend0", {31'b0, pend0}, 32'h0);
    check("arst_pend1", {31'b0, pend1}, 32'h0);
    check("arst_valid0", {31'b0, valid0}, 32'h0);
    check("arst_valid1", {31'b0, valid1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    tick();
    check("post_rst_iaddr0", iaddr0, 32'h4);
    check("post_rst_pc1", pc1, 32'h1000);
    check("post_rst_pend1", {31'b0, pend1}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
